// File: rtl/mvm_sched.sv
// Sequencing controller for a lane-parallel y = A*x datapath: loads x and A from a
// byte stream, issues chunked read addresses with a tag pipe, then streams y out.
module mvm_sched #(
  parameter int N        = 4,
  parameter int LANES    = 4,
  parameter int AW       = 6,
  parameter int MEM_LAT  = 1,
  parameter int PIPE_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                wr_en_x,
  output logic                wr_en_a,
  output logic [AW-1:0]       wr_addr,
  output logic [LANES*AW-1:0] rd_addr_x,
  output logic [LANES*AW-1:0] rd_addr_a,
  output logic                acc_clear,
  output logic                acc_en,
  output logic                wr_en_y,
  output logic [AW-1:0]       addr_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int K = N / LANES;
  localparam int D = MEM_LAT + PIPE_LAT;

  localparam logic [AW-1:0] LAST_X     = AW'(N - 1);
  localparam logic [AW-1:0] LAST_A     = AW'(N * N - 1);
  localparam logic [AW-1:0] LAST_ROW   = AW'(N - 1);
  localparam logic [AW-1:0] LAST_CHUNK = AW'(K - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_A,
    COMPUTE,
    OUTPUT
  } state_t;

  // Travels alongside a chunk from issue to the accumulator input.
  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [AW-1:0] row;
  } tag_t;

  state_t        state;
  logic [AW-1:0] issue_row;
  logic [AW-1:0] issue_chunk;
  logic [AW-1:0] next_row;
  logic [AW-1:0] next_chunk;
  logic          issue_more;
  tag_t          next_tag;
  tag_t          first_tag;
  tag_t          tag_pipe [0:D];

  function automatic logic [LANES*AW-1:0] x_addrs(input logic [AW-1:0] chunk);
    logic [LANES*AW-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      v[l*AW +: AW] = chunk * AW'(LANES) + AW'(l);
    end
    return v;
  endfunction

  function automatic logic [LANES*AW-1:0] a_addrs(input logic [AW-1:0] row,
                                                  input logic [AW-1:0] chunk);
    logic [LANES*AW-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      v[l*AW +: AW] = row * AW'(N) + chunk * AW'(LANES) + AW'(l);
    end
    return v;
  endfunction

  always_comb begin
    next_chunk = (issue_chunk == LAST_CHUNK) ? '0 : issue_chunk + 1'b1;
    next_row   = (issue_chunk == LAST_CHUNK) ? issue_row + 1'b1 : issue_row;
    issue_more = tag_pipe[0].valid &&
                 !(issue_chunk == LAST_CHUNK && issue_row == LAST_ROW);
    next_tag   = '{valid: 1'b1, first: (next_chunk == '0),
                   last: (next_chunk == LAST_CHUNK), row: next_row};
    first_tag  = '{valid: 1'b1, first: 1'b1, last: (K == 1), row: '0};
  end

  // NOTE: the load strobes are combinational so a beat is written in the cycle it is accepted.
  assign wr_en_x   = in_valid && in_ready && (state == LOAD_X);
  assign wr_en_a   = in_valid && in_ready && (state == LOAD_A);
  assign acc_en    = tag_pipe[D].valid;
  assign acc_clear = tag_pipe[D].valid && tag_pipe[D].first;
  assign out_last  = out_valid && (addr_y == LAST_ROW);
  assign busy      = (state != IDLE);

  // NOTE: synchronous reset clears every flop, including the small tag pipe array,
  // so an aborted job can never leak a stale accumulate or y write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      wr_addr     <= '0;
      rd_addr_x   <= '0;
      rd_addr_a   <= '0;
      issue_row   <= '0;
      issue_chunk <= '0;
      wr_en_y     <= 1'b0;
      addr_y      <= '0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      for (int k = 0; k <= D; k++) tag_pipe[k] <= '0;
    end else begin
      done        <= 1'b0;
      tag_pipe[0] <= '0;
      for (int k = 1; k <= D; k++) tag_pipe[k] <= tag_pipe[k-1];

      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD_X;
            in_ready <= 1'b1;
            wr_addr  <= '0;
          end
        end

        LOAD_X: begin
          if (in_valid) begin
            if (wr_addr == LAST_X) begin
              state   <= LOAD_A;
              wr_addr <= '0;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end

        LOAD_A: begin
          if (in_valid) begin
            if (wr_addr == LAST_A) begin
              // Issue chunk (0,0) on the transition so COMPUTE starts reading at once.
              state       <= COMPUTE;
              in_ready    <= 1'b0;
              wr_addr     <= '0;
              issue_row   <= '0;
              issue_chunk <= '0;
              tag_pipe[0] <= first_tag;
              rd_addr_x   <= x_addrs('0);
              rd_addr_a   <= a_addrs('0, '0);
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end

        COMPUTE: begin
          if (issue_more) begin
            issue_row   <= next_row;
            issue_chunk <= next_chunk;
            tag_pipe[0] <= next_tag;
            rd_addr_x   <= x_addrs(next_chunk);
            rd_addr_a   <= a_addrs(next_row, next_chunk);
          end
          if (wr_en_y && addr_y == LAST_ROW) begin
            state     <= OUTPUT;
            wr_en_y   <= 1'b0;
            addr_y    <= '0;
            out_valid <= 1'b0;
          end else begin
            wr_en_y <= tag_pipe[D].valid && tag_pipe[D].last;
            if (tag_pipe[D].valid && tag_pipe[D].last) addr_y <= tag_pipe[D].row;
          end
        end

        OUTPUT: begin
          // A cycle with out_valid low lets the y memory read settle after each address change.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (addr_y == LAST_ROW) begin
              state  <= IDLE;
              done   <= 1'b1;
              addr_y <= '0;
            end else begin
              addr_y <= addr_y + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_sched.sv
// Directed bench for mvm_sched: two instances (N=4 and N=8) each wrapped in a small
// behavioural x/A/y memory and MAC model; y values are checked against hand-computed constants.
module tb_mvm_sched;

  localparam int AW    = 7;
  localparam int LANES = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              start;
  logic              in_valid;
  logic              out_ready;
  logic signed [7:0] data_in;
  int                sel;

  logic                in_ready, wr_en_x, wr_en_a, acc_clear, acc_en, wr_en_y;
  logic                out_valid, out_last, busy, done;
  logic [AW-1:0]       wr_addr, addr_y;
  logic [LANES*AW-1:0] rd_addr_x, rd_addr_a;
  int                  data_out;

  int passed   = 0;
  int total    = 0;
  int done_cnt = 0;
  int nn;
  int x_v [8];
  int a_v [64];
  int y_exp [8];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int NN = (g == 0) ? 4 : 8;

    logic                start_i, in_valid_i, out_ready_i;
    logic                in_ready, wr_en_x, wr_en_a, acc_clear, acc_en, wr_en_y;
    logic                out_valid, out_last, busy, done;
    logic [AW-1:0]       wr_addr, addr_y;
    logic [LANES*AW-1:0] rd_addr_x, rd_addr_a;

    logic signed [7:0] xmem [0:127];
    logic signed [7:0] amem [0:127];
    logic signed [7:0] xq [LANES];
    logic signed [7:0] aq [LANES];
    int                ymem [0:127];
    int                lsum, psum, acc, data_out;

    assign start_i     = start && (sel == g);
    assign in_valid_i  = in_valid && (sel == g);
    assign out_ready_i = out_ready && (sel == g);

    mvm_sched #(.N(NN), .LANES(LANES), .AW(AW), .MEM_LAT(1), .PIPE_LAT(1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start_i),
      .in_valid  (in_valid_i),
      .in_ready  (in_ready),
      .wr_en_x   (wr_en_x),
      .wr_en_a   (wr_en_a),
      .wr_addr   (wr_addr),
      .rd_addr_x (rd_addr_x),
      .rd_addr_a (rd_addr_a),
      .acc_clear (acc_clear),
      .acc_en    (acc_en),
      .wr_en_y   (wr_en_y),
      .addr_y    (addr_y),
      .out_valid (out_valid),
      .out_ready (out_ready_i),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
    );

    always_comb begin
      lsum = 0;
      for (int l = 0; l < LANES; l++) lsum += int'(xq[l]) * int'(aq[l]);
    end

    // Memories with one cycle read latency, one pipeline register, accumulator, y memory.
    always @(posedge clk) begin
      if (wr_en_x) xmem[wr_addr] <= data_in;
      if (wr_en_a) amem[wr_addr] <= data_in;
      for (int l = 0; l < LANES; l++) begin
        xq[l] <= xmem[rd_addr_x[l*AW +: AW]];
        aq[l] <= amem[rd_addr_a[l*AW +: AW]];
      end
      psum <= lsum;
      if (acc_en) acc <= acc_clear ? psum : acc + psum;
      if (wr_en_y) ymem[addr_y] <= acc;
      data_out <= ymem[addr_y];
    end
  end

  always_comb begin
    if (sel == 0) begin
      in_ready  = g_inst[0].in_ready;   wr_en_x   = g_inst[0].wr_en_x;
      wr_en_a   = g_inst[0].wr_en_a;    acc_clear = g_inst[0].acc_clear;
      acc_en    = g_inst[0].acc_en;     wr_en_y   = g_inst[0].wr_en_y;
      out_valid = g_inst[0].out_valid;  out_last  = g_inst[0].out_last;
      busy      = g_inst[0].busy;       done      = g_inst[0].done;
      wr_addr   = g_inst[0].wr_addr;    addr_y    = g_inst[0].addr_y;
      rd_addr_x = g_inst[0].rd_addr_x;  rd_addr_a = g_inst[0].rd_addr_a;
      data_out  = g_inst[0].data_out;
    end else begin
      in_ready  = g_inst[1].in_ready;   wr_en_x   = g_inst[1].wr_en_x;
      wr_en_a   = g_inst[1].wr_en_a;    acc_clear = g_inst[1].acc_clear;
      acc_en    = g_inst[1].acc_en;     wr_en_y   = g_inst[1].wr_en_y;
      out_valid = g_inst[1].out_valid;  out_last  = g_inst[1].out_last;
      busy      = g_inst[1].busy;       done      = g_inst[1].done;
      wr_addr   = g_inst[1].wr_addr;    addr_y    = g_inst[1].addr_y;
      rd_addr_x = g_inst[1].rd_addr_x;  rd_addr_a = g_inst[1].rd_addr_a;
      data_out  = g_inst[1].data_out;
    end
  end

  always @(posedge clk) if (done) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=400000", $time);
    $fatal(1);
  end

  task automatic start_job();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_vectors(input bit gap, input int abort_at, output int cycles);
    int idx;
    bit is_x;
    cycles = 0;
    for (int i = 0; i < nn + nn * nn; i++) begin
      is_x = (i < nn);
      idx  = is_x ? i : i - nn;
      if (gap) begin
        in_valid = 1'b0;
        #1;
        if ({wr_en_x, wr_en_a} !== 2'b00)
          $display("FAIL gap_strobe beat %0d: wr_en_x=%b wr_en_a=%b expected 0 0", i, wr_en_x, wr_en_a);
        else passed++;
        total++;
        @(negedge clk);
        cycles++;
      end
      in_valid = 1'b1;
      data_in  = is_x ? x_v[idx][7:0] : a_v[idx][7:0];
      if (i == abort_at) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      #1;
      if (in_ready !== 1'b1 || wr_en_x !== is_x || wr_en_a !== !is_x || wr_addr !== AW'(idx))
        $display("FAIL load_beat %0d: in_ready=%b wr_en_x=%b wr_en_a=%b wr_addr=%0d expected 1 %b %b %0d",
                 i, in_ready, wr_en_x, wr_en_a, wr_addr, is_x, !is_x, idx);
      else passed++;
      total++;
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    #1;
    if (in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL load_exit: in_ready=%b busy=%b expected 0 1", in_ready, busy);
    else passed++;
    total++;
  endtask

  task automatic run_compute(input bit pulse_start);
    int cyc, n_en, n_clr, n_wy, nk, exp_x3;
    cyc = 0; n_en = 0; n_clr = 0; n_wy = 0;
    nk     = nn * (nn / LANES);
    exp_x3 = (nn == 4) ? 3 : 7;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (acc_en === 1'b1) n_en++;
      if (acc_clear === 1'b1) n_clr++;
      if (wr_en_y === 1'b1) n_wy++;
      if (cyc == 1) begin
        if (rd_addr_a[AW-1:0] !== AW'(4) || rd_addr_x[3*AW +: AW] !== AW'(exp_x3))
          $display("FAIL issue_addr: a_lane0=%0d x_lane3=%0d expected 4 %0d",
                   rd_addr_a[AW-1:0], rd_addr_x[3*AW +: AW], exp_x3);
        else passed++;
        total++;
      end
      if (pulse_start) start = (cyc == 2);
      @(negedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    if (cyc !== nk + 4)
      $display("FAIL compute_len: first out_valid after %0d cycles expected %0d", cyc, nk + 4);
    else passed++;
    total++;
    if (n_en !== nk || n_clr !== nn || n_wy !== nn)
      $display("FAIL compute_strobes: acc_en=%0d acc_clear=%0d wr_en_y=%0d expected %0d %0d %0d",
               n_en, n_clr, n_wy, nk, nn, nn);
    else passed++;
    total++;
  endtask

  task automatic collect(input int stall_idx, input bit start_at_last);
    int wait_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < nn; i++) begin
      wait_cnt = 0;
      while (out_valid !== 1'b1 && wait_cnt < 8) begin
        @(negedge clk);
        #1;
        wait_cnt++;
      end
      if (out_valid !== 1'b1 || addr_y !== AW'(i) || data_out !== y_exp[i] || out_last !== (i == nn - 1))
        $display("FAIL y[%0d]: valid=%b addr_y=%0d data_out=%0d last=%b expected 1 %0d %0d %b",
                 i, out_valid, addr_y, data_out, out_last, i, y_exp[i], (i == nn - 1));
      else passed++;
      total++;
      if (i == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          #1;
          if (out_valid !== 1'b1 || data_out !== y_exp[i] || addr_y !== AW'(i))
            $display("FAIL stall_hold %0d: valid=%b data_out=%0d addr_y=%0d expected 1 %0d %0d",
                     s, out_valid, data_out, addr_y, y_exp[i], i);
          else passed++;
          total++;
        end
        out_ready = 1'b1;
      end
      if (start_at_last && i == nn - 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      if (i < nn - 1) begin
        if (out_valid !== 1'b0 || busy !== 1'b1)
          $display("FAIL out_gap %0d: valid=%b busy=%b expected 0 1", i, out_valid, busy);
        else passed++;
      end else begin
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
          $display("FAIL done_pulse: done=%b busy=%b valid=%b expected 1 0 0", done, busy, out_valid);
        else passed++;
      end
      total++;
    end
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_width: done=%b busy=%b expected 0 0", done, busy);
    else passed++;
    total++;
  endtask

  task automatic set_ramp_job(input int n);
    nn = n;
    for (int j = 0; j < n; j++) x_v[j] = j + 1;
    for (int j = 0; j < n * n; j++) a_v[j] = j;
  endtask

  task automatic check_idle_zero(input string name);
    if ({busy, in_ready, out_valid, done, out_last} !== 5'b0)
      $display("FAIL %s_ctrl: busy=%b in_ready=%b out_valid=%b done=%b out_last=%b expected 0",
               name, busy, in_ready, out_valid, done, out_last);
    else passed++;
    total++;
    if (wr_addr !== '0 || addr_y !== '0 || rd_addr_x !== '0 || rd_addr_a !== '0)
      $display("FAIL %s_addr: wr_addr=%0d addr_y=%0d rd_addr_x=%h rd_addr_a=%h expected 0",
               name, wr_addr, addr_y, rd_addr_x, rd_addr_a);
    else passed++;
    total++;
    if ({acc_en, acc_clear, wr_en_y, wr_en_x, wr_en_a} !== 5'b0)
      $display("FAIL %s_strobe: acc_en=%b acc_clear=%b wr_en_y=%b wr_en_x=%b wr_en_a=%b expected 0",
               name, acc_en, acc_clear, wr_en_y, wr_en_x, wr_en_a);
    else passed++;
    total++;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; sel = 0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("reset");
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, d0;
    sel = 0;
    set_ramp_job(4);
    y_exp[0] = 20; y_exp[1] = 60; y_exp[2] = 100; y_exp[3] = 140;
    d0 = done_cnt;
    start_job();
    load_vectors(1'b0, -1, cyc);
    if (cyc !== 20) $display("FAIL load_len: %0d cycles expected 20", cyc);
    else passed++;
    total++;
    run_compute(1'b0);
    collect(-1, 1'b0);
    if (done_cnt - d0 !== 1) $display("FAIL basic_done_count: %0d expected 1", done_cnt - d0);
    else passed++;
    total++;
  endtask

  task automatic test_input_gaps();
    int cyc;
    start_job();
    load_vectors(1'b1, -1, cyc);
    if (cyc !== 40) $display("FAIL gap_load_len: %0d cycles expected 40", cyc);
    else passed++;
    total++;
    run_compute(1'b0);
    collect(-1, 1'b0);
  endtask

  task automatic test_backpressure();
    int cyc;
    start_job();
    load_vectors(1'b0, -1, cyc);
    run_compute(1'b0);
    collect(1, 1'b0);
  endtask

  task automatic test_reset_mid_job();
    int cyc;
    start_job();
    load_vectors(1'b0, 4 + 7, cyc);
    #1;
    check_idle_zero("midreset");
    in_valid = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      x_v[j]   = (j % 2 == 0) ? -1 : 1;
      y_exp[j] = 2;
    end
    start_job();
    load_vectors(1'b0, -1, cyc);
    run_compute(1'b0);
    collect(-1, 1'b0);
  endtask

  task automatic test_start_outside_idle();
    int cyc, d0;
    set_ramp_job(4);
    y_exp[0] = 20; y_exp[1] = 60; y_exp[2] = 100; y_exp[3] = 140;
    d0 = done_cnt;
    start_job();
    load_vectors(1'b0, -1, cyc);
    run_compute(1'b1);
    collect(-1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    if (busy !== 1'b0 || done_cnt - d0 !== 1)
      $display("FAIL stray_start: busy=%b done_count=%0d expected 0 1", busy, done_cnt - d0);
    else passed++;
    total++;
  endtask

  task automatic test_signed_extremes(input int n, input int y_val);
    int cyc;
    sel = (n == 4) ? 0 : 1;
    nn  = n;
    for (int j = 0; j < n; j++) begin
      x_v[j]   = -128;
      y_exp[j] = y_val;
    end
    for (int j = 0; j < n * n; j++) a_v[j] = 127;
    @(negedge clk);
    start_job();
    load_vectors(1'b0, -1, cyc);
    run_compute(1'b0);
    collect(-1, 1'b0);
  endtask

  task automatic test_accumulate_n8();
    int cyc;
    sel = 1;
    set_ramp_job(8);
    y_exp[0] = 168;  y_exp[1] = 456;  y_exp[2] = 744;  y_exp[3] = 1032;
    y_exp[4] = 1320; y_exp[5] = 1608; y_exp[6] = 1896; y_exp[7] = 2184;
    @(negedge clk);
    start_job();
    load_vectors(1'b0, -1, cyc);
    if (cyc !== 72) $display("FAIL n8_load_len: %0d cycles expected 72", cyc);
    else passed++;
    total++;
    run_compute(1'b0);
    collect(2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_input_gaps();
    test_backpressure();
    test_reset_mid_job();
    test_start_outside_idle();
    test_signed_extremes(4, -65024);
    test_signed_extremes(8, -130048);
    test_accumulate_n8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
